// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   clog2   : ceiling log2, used to size the digit counter
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit subtractor: diff = a - b - bin, bout = borrow-out.
// Ports:
//   diff [DIGIT] out  digit difference
//   bout         out  borrow out of the MSB cell
//   a    [DIGIT] in   minuend digit
//   b    [DIGIT] in   subtrahend digit
//   bin          in   borrow into the LSB cell
// Each cell is a full subtractor built from two half subtractors plus an OR;
// the borrow ripples LSB to MSB.
module digit_subtractor #(
   parameter int unsigned DIGIT = 4
) (
   output logic [DIGIT-1:0] diff,
   output logic             bout,
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin
);

   logic [DIGIT:0] br;

   assign br[0] = bin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      logic hd;
      logic hb1;
      logic hb2;
      // first half subtractor: a - b
      assign hd  = a[i] ^ b[i];
      assign hb1 = ~a[i] & b[i];
      // second half subtractor: (a - b) - borrow
      assign diff[i] = hd ^ br[i];
      assign hb2     = ~hd & br[i];
      assign br[i+1] = hb1 | hb2;
   end

   assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   in_valid  in   operands valid
//   in_ready  out  block can accept operands (IDLE and not in reset)
//   a, b      in   minuend / subtrahend [WIDTH]
//   bin       in   borrow-in
//   out_valid out  result valid (DONE)
//   out_ready in   consumer accepts result
//   diff      out  a - b - bin mod 2^WIDTH [WIDTH]
//   bout      out  unsigned borrow-out
//   zero      out  diff == 0
//   ovf       out  two's-complement signed overflow
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? clog2(NDIG) : 1;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_r;
   logic [WIDTH-1:0] diff_nx;
   logic             borrow_r;
   logic             zero_acc;
   logic             a_msb;
   logic             b_msb;
   logic [CW-1:0]    count;
   logic [DIGIT-1:0] dig_d;
   logic             dig_b;
   logic             accept;
   logic             last;

   digit_subtractor #(
      .DIGIT(DIGIT)
   ) u_digit (
      .diff(dig_d),
      .bout(dig_b),
      .a   (a_sh[DIGIT-1:0]),
      .b   (b_sh[DIGIT-1:0]),
      .bin (borrow_r)
   );

   assign in_ready = (state == S_IDLE) & ~rst;
   assign accept   = in_valid & in_ready;
   assign last     = (count == CW'(NDIG - 1));

   // New digit enters from the MSB side; written as shift/OR so DIGIT==WIDTH
   // needs no zero-width slice.
   assign diff_nx = (diff_r >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (accept)    state_nx = S_RUN;
         S_RUN:  if (last)      state_nx = S_DONE;
         S_DONE: if (out_ready) state_nx = S_IDLE;
         default:               state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
         zero_acc <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         count    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow_r <= bin;
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
                  count    <= '0;
                  zero_acc <= 1'b1;
               end
            end
            S_RUN: begin
               a_sh     <= a_sh >> DIGIT;
               b_sh     <= b_sh >> DIGIT;
               diff_r   <= diff_nx;
               borrow_r <= dig_b;
               zero_acc <= zero_acc & (dig_d == '0);
               count    <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state == S_DONE);
   assign diff      = diff_r;
   assign bout      = out_valid & borrow_r;
   assign zero      = out_valid & zero_acc;
   assign ovf       = out_valid & (a_msb != b_msb) & (diff_r[WIDTH-1] != a_msb);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        z;
      logic        ov;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;

   logic [2:0]  irdy;
   logic [2:0]  ovld;
   logic [2:0]  bo;
   logic [2:0]  zr;
   logic [2:0]  of;
   logic [15:0] df [3];

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned dig  [3] = '{4, 1, 16};
   int unsigned ndig [3] = '{4, 16, 1};

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
      .a(a), .b(b), .bin(bin), .out_valid(ovld[0]), .out_ready(out_ready),
      .diff(df[0]), .bout(bo[0]), .zero(zr[0]), .ovf(of[0])
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
      .a(a), .b(b), .bin(bin), .out_valid(ovld[1]), .out_ready(out_ready),
      .diff(df[1]), .bout(bo[1]), .zero(zr[1]), .ovf(of[1])
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]),
      .a(a), .b(b), .bin(bin), .out_valid(ovld[2]), .out_ready(out_ready),
      .diff(df[2]), .bout(bo[2]), .zero(zr[2]), .ovf(of[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
      res_t r;
      int   u;
      int   s;
      u    = int'(ma) - int'(mb) - int'(mbin);
      s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      r.d  = u[15:0];
      r.bo = (u < 0);
      r.z  = (r.d == 16'h0000);
      r.ov = (s < -32768) || (s > 32767);
      return r;
   endfunction

   // Issues one op with out_ready=1 and checks every DUT's result and latency.
   task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin, input string name);
      res_t e;
      bit   seen [3];
      e = model(oa, ob, obin);
      for (int d = 0; d < 3; d++) begin
         seen[d] = 1'b0;
         check($sformatf("%s/D%0d in_ready", name, dig[d]), 32'(irdy[d]), 32'd1);
      end
      a = oa; b = ob; bin = obin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            if (!seen[d] && ovld[d]) begin
               seen[d] = 1'b1;
               check($sformatf("%s/D%0d latency", name, dig[d]), 32'(cyc), ndig[d]);
               check($sformatf("%s/D%0d diff", name, dig[d]), 32'(df[d]), 32'(e.d));
               check($sformatf("%s/D%0d bout", name, dig[d]), 32'(bo[d]), 32'(e.bo));
               check($sformatf("%s/D%0d zero", name, dig[d]), 32'(zr[d]), 32'(e.z));
               check($sformatf("%s/D%0d ovf", name, dig[d]), 32'(of[d]), 32'(e.ov));
            end
         end
      end
      for (int d = 0; d < 3; d++)
         if (!seen[d]) check($sformatf("%s/D%0d timeout", name, dig[d]), 32'd0, 32'd1);
   endtask

   initial begin
      res_t        e;
      int unsigned bad;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset/D%0d out_valid", dig[d]), 32'(ovld[d]), 32'd0);
         check($sformatf("reset/D%0d in_ready", dig[d]), 32'(irdy[d]), 32'd0);
         check($sformatf("reset/D%0d diff", dig[d]), 32'(df[d]), 32'd0);
         check($sformatf("reset/D%0d flags", dig[d]), 32'({bo[d], zr[d], of[d]}), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(16'h1234, 16'h0034, 1'b0, "basic");
      run_op(16'h0000, 16'h0001, 1'b0, "underflow");
      run_op(16'h8000, 16'h0001, 1'b0, "sovf");
      run_op(16'h0005, 16'h0002, 1'b1, "bin");
      run_op(16'h5555, 16'h5555, 1'b0, "zero");
      run_op(16'h1000, 16'h0001, 1'b0, "ripple");
      run_op(16'h8000, 16'h0000, 1'b1, "bin_ovf");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, "pos_ovf");
      for (int i = 0; i < 12; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rand%0d", i));

      // Backpressure: results must hold while out_ready=0, new input ignored.
      out_ready = 1'b0;
      e = model(16'h1000, 16'h0001, 1'b0);
      a = 16'h1000; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      for (int h = 0; h < 3; h++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         for (int d = 0; d < 3; d++) begin
            check($sformatf("bp%0d/D%0d out_valid", h, dig[d]), 32'(ovld[d]), 32'd1);
            check($sformatf("bp%0d/D%0d in_ready", h, dig[d]), 32'(irdy[d]), 32'd0);
            check($sformatf("bp%0d/D%0d diff", h, dig[d]), 32'(df[d]), 32'(e.d));
            check($sformatf("bp%0d/D%0d bout", h, dig[d]), 32'(bo[d]), 32'(e.bo));
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("bp_rel/D%0d out_valid", dig[d]), 32'(ovld[d]), 32'd0);
         check($sformatf("bp_rel/D%0d in_ready", dig[d]), 32'(irdy[d]), 32'd1);
      end

      // Reset two cycles into an op: DIGIT=16 is in DONE, the others mid-RUN.
      out_ready = 1'b0;
      a = 16'h1234; b = 16'h0034; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("midrst/D%0d out_valid", dig[d]), 32'(ovld[d]), 32'd0);
         check($sformatf("midrst/D%0d in_ready", dig[d]), 32'(irdy[d]), 32'd0);
         check($sformatf("midrst/D%0d diff", dig[d]), 32'(df[d]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("postrst/D%0d in_ready", dig[d]), 32'(irdy[d]), 32'd1);
      bad = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk); #1;
         if (ovld != 3'b000) bad++;
      end
      check("postrst no_emit", bad, 32'd0);
      out_ready = 1'b1;
      run_op(16'h1234, 16'h0034, 1'b0, "post_rst_basic");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
